// File: rtl/button_debounce_fsm.sv
// ---------------------------------------------------------------------------
// button_debounce_fsm
//
// Debounces and classifies the synchronized push-button level coming from the
// button-conditioning stage. The FSM runs on the board clock but only moves
// on cycles where the 1200 Hz enable `tick` is high. It produces a clean
// pressed level, one-clock press/release/auto-repeat pulses and an 8-bit
// wrapping press counter.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   -> HOLD state and auto-repeat `hold_pulse` are built
//   undefined -> no HOLD state, `hold_pulse` tied to 0
//
// Ports
//   clock          in   board clock, all state changes on the rising edge
//   reset          in   synchronous, active-high reset
//   tick           in   one-clock 1200 Hz enable
//   btn_in         in   synchronized button level (polarity set by ACTIVE_LOW)
//   level          out  debounced pressed state, 1 = pressed
//   press_pulse    out  one-clock pulse on accepted press
//   release_pulse  out  one-clock pulse on accepted release
//   hold_pulse     out  one-clock pulse on first and each later auto-repeat
//   press_count    out  accepted presses, modulo 256
// ---------------------------------------------------------------------------
module button_debounce_fsm #(
    parameter bit          ACTIVE_LOW     = 1'b1,
    parameter int unsigned DEBOUNCE_TICKS = 24,
    parameter int unsigned HOLD_TICKS     = 1200,
    parameter int unsigned REPEAT_TICKS   = 240,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_in,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       hold_pulse,
    output logic [7:0] press_count
);

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRESS_WAIT   = 3'd1,
        S_PRESSED      = 3'd2,
        S_HOLD         = 3'd3,
        S_RELEASE_WAIT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`else
    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRESS_WAIT   = 3'd1,
        S_PRESSED      = 3'd2,
        S_RELEASE_WAIT = 3'd4
    } state_t;

    // Without auto-repeat the PRESSED count is never compared; it saturates
    // at the longest hold/repeat interval instead of wrapping.
    localparam int unsigned      TIMER_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam logic [CNT_W-1:0] TIMER_TOP = CNT_W'(TIMER_MAX - 1);
`endif

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic [7:0]       press_count_q, press_count_d;
    logic             raw;

`ifdef BTN_AUTOREPEAT_EN
    logic             hold_pulse_q, hold_pulse_d;
`endif

    // Normalise polarity so that raw = 1 always means "pressed".
    assign raw = btn_in ^ ACTIVE_LOW;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        level_d         = level_q;
        press_count_d   = press_count_q;
        // Pulses self-clear every cycle, including cycles without a tick.
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        hold_pulse_d    = 1'b0;
`endif

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (raw) begin
                        state_d = S_PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end

                S_PRESS_WAIT: begin
                    if (!raw) begin
                        // Bounce: drop back silently.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d       = S_PRESSED;
                        level_d       = 1'b1;
                        press_pulse_d = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                        cnt_d         = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                S_PRESSED: begin
                    if (!raw) begin
                        state_d = S_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
`ifdef BTN_AUTOREPEAT_EN
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d      = S_HOLD;
                        hold_pulse_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`else
                    end else if (cnt_q != TIMER_TOP) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`endif
                end

`ifdef BTN_AUTOREPEAT_EN
                S_HOLD: begin
                    if (!raw) begin
                        state_d = S_RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == REPEAT_LAST) begin
                        hold_pulse_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif

                S_RELEASE_WAIT: begin
                    if (raw) begin
                        // Release rejected: hold timing restarts from zero
                        // and any auto-repeat run is abandoned.
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d         = S_IDLE;
                        level_d         = 1'b0;
                        release_pulse_d = 1'b1;
                        cnt_d           = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end
    end

    // Reset has priority, so a tick arriving in a reset cycle is discarded.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            level_q         <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= 8'd0;
`ifdef BTN_AUTOREPEAT_EN
            hold_pulse_q    <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            level_q         <= level_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
`ifdef BTN_AUTOREPEAT_EN
            hold_pulse_q    <= hold_pulse_d;
`endif
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;
`ifdef BTN_AUTOREPEAT_EN
    assign hold_pulse    = hold_pulse_q;
`else
    assign hold_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce_fsm.sv
// ---------------------------------------------------------------------------
// tb_button_debounce_fsm
//
// Self-checking bench for button_debounce_fsm with default parameters.
// A run-length reference model (consecutive disagreeing ticks, pressed ticks
// since the last press/repeat event) predicts every output after every tick
// and idle cycle. Segment tables and hand-written sequences additionally
// check pulse totals and repeat positions against fixed constants.
// ---------------------------------------------------------------------------
module tb_button_debounce_fsm;

    localparam bit ACTIVE_LOW = 1'b1;
    localparam int D = 24;
    localparam int H = 1200;
    localparam int R = 240;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_in;
    logic       level;
    logic       press_pulse;
    logic       release_pulse;
    logic       hold_pulse;
    logic [7:0] press_count;

    button_debounce_fsm #(
        .ACTIVE_LOW    (ACTIVE_LOW),
        .DEBOUNCE_TICKS(D),
        .HOLD_TICKS    (H),
        .REPEAT_TICKS  (R),
        .CNT_W         (11)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .btn_in       (btn_in),
        .level        (level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse),
        .press_count  (press_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_level, m_pend, m_since, m_count;
    bit m_repeating;
    bit e_press, e_release, e_hold;

    // Segment statistics
    int seg_press, seg_release, seg_hold, tick_idx;
    int hold_at[$];
    int exp_hold_at[$];

    typedef struct {
        bit pressed;
        int n;
        bit exp_level;
        int exp_press;
        int exp_release;
        int exp_hold;
        int exp_count;
    } seg_t;

    seg_t table_v[8];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_pend = 0; m_since = 0; m_count = 0; m_repeating = 0;
        e_press = 0; e_release = 0; e_hold = 0;
    endtask

    // Run-length view of the debouncer: m_pend counts consecutive ticks that
    // disagree with the accepted level; m_since counts pressed ticks since the
    // press, the last repeat, or a rejected release.
    task automatic model_tick(input bit p);
        e_press = 0; e_release = 0; e_hold = 0;
        if (m_level == 0) begin
            if (p) begin
                m_pend++;
                if (m_pend == D) begin
                    m_level = 1; e_press = 1; m_count = (m_count + 1) % 256;
                    m_pend = 0; m_since = 0; m_repeating = 0;
                end
            end else begin
                m_pend = 0;
            end
        end else if (!p) begin
            m_pend++;
            if (m_pend == D) begin
                m_level = 0; e_release = 1; m_pend = 0;
            end
        end else if (m_pend != 0) begin
            m_pend = 0; m_since = 0; m_repeating = 0;
        end else begin
            m_since++;
            if (AUTOREP && m_since == (m_repeating ? R : H)) begin
                e_hold = 1; m_since = 0; m_repeating = 1;
            end
        end
    endtask

    task automatic compare_outputs(input string tag, input bit ep, input bit er, input bit eh);
        check({tag, " level"}, level, m_level);
        check({tag, " press_pulse"}, press_pulse, ep);
        check({tag, " release_pulse"}, release_pulse, er);
        check({tag, " hold_pulse"}, hold_pulse, eh);
        check({tag, " press_count"}, press_count, m_count);
    endtask

    // Called just after a falling edge. Applies one tick, then gap-1 idle
    // cycles with random btn_in (which must be ignored).
    task automatic apply_tick(input bit p, input int gap);
        btn_in = p ^ ACTIVE_LOW;
        tick   = 1'b1;
        @(posedge clock);
        model_tick(p);
        @(negedge clock);
        tick = 1'b0;
        tick_idx++;
        compare_outputs("tick", e_press, e_release, e_hold);
        if (press_pulse === 1'b1)   seg_press++;
        if (release_pulse === 1'b1) seg_release++;
        if (hold_pulse === 1'b1) begin
            seg_hold++;
            hold_at.push_back(tick_idx);
        end
        for (int i = 1; i < gap; i++) begin
            btn_in = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            compare_outputs("idle", 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input int n, input bit p);
        reset  = 1'b1;
        tick   = 1'b1;
        btn_in = p ^ ACTIVE_LOW;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
        model_reset();
        compare_outputs("reset", 1'b0, 1'b0, 1'b0);
        check("reset press_count zero", press_count, 0);
        reset = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic clear_seg();
        seg_press = 0; seg_release = 0; seg_hold = 0; tick_idx = 0;
        hold_at.delete();
    endtask

    task automatic run_ticks(input bit p, input int n, input int gap);
        for (int i = 0; i < n; i++) apply_tick(p, gap);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; btn_in = 1'b1;
        model_reset();
        clear_seg();

        // Segment table: pressed, ticks, level, press, release, hold, count
        table_v[0] = '{1'b1, 24, 1'b1, 1, 0, 0, 1};  // full debounce press
        table_v[1] = '{1'b0, 24, 1'b0, 0, 1, 0, 1};  // full debounce release
        table_v[2] = '{1'b1, 23, 1'b0, 0, 0, 0, 1};  // one tick short
        table_v[3] = '{1'b0,  1, 1'b0, 0, 0, 0, 1};  // ...then released
        table_v[4] = '{1'b1, 24, 1'b1, 1, 0, 0, 2};  // press again
        table_v[5] = '{1'b0, 10, 1'b1, 0, 0, 0, 2};  // short release glitch
        table_v[6] = '{1'b1,  1, 1'b1, 0, 0, 0, 2};  // back to pressed
        table_v[7] = '{1'b0, 24, 1'b0, 0, 1, 0, 2};  // real release

        @(negedge clock);
        do_reset(3, 1'b0);

        foreach (table_v[k]) begin
            clear_seg();
            run_ticks(table_v[k].pressed, table_v[k].n, 4);
            check($sformatf("seg%0d level", k), level, table_v[k].exp_level);
            check($sformatf("seg%0d press pulses", k), seg_press, table_v[k].exp_press);
            check($sformatf("seg%0d release pulses", k), seg_release, table_v[k].exp_release);
            check($sformatf("seg%0d hold pulses", k), seg_hold, table_v[k].exp_hold);
            check($sformatf("seg%0d press_count", k), press_count, table_v[k].exp_count);
            $display("segment %0d: pressed=%0d ticks=%0d level=%0d count=%0d",
                     k, table_v[k].pressed, table_v[k].n, level, press_count);
        end

        // Bounce: alternating samples never qualify, then a clean press does.
        clear_seg();
        for (int i = 0; i < 100; i++) apply_tick((i % 2) == 0, 4);
        check("bounce press pulses", seg_press, 0);
        check("bounce release pulses", seg_release, 0);
        check("bounce level", level, 0);
        run_ticks(1'b1, 24, 4);
        check("bounce then press pulses", seg_press, 1);
        check("bounce then press count", press_count, 3);
        run_ticks(1'b0, 24, 4);
        $display("bounce sequence: presses=%0d count=%0d", seg_press, press_count);

        // Long hold: repeats at ticks 24+1200, then every 240.
        exp_hold_at.delete();
`ifdef BTN_AUTOREPEAT_EN
        exp_hold_at.push_back(D + H);
        exp_hold_at.push_back(D + H + R);
        exp_hold_at.push_back(D + H + 2 * R);
        exp_hold_at.push_back(D + H + 3 * R);
`endif
        clear_seg();
        run_ticks(1'b1, D + H + 3 * R, 4);
        check("hold pulse total", hold_at.size(), exp_hold_at.size());
        for (int i = 0; i < hold_at.size() && i < exp_hold_at.size(); i++)
            check($sformatf("hold pulse %0d tick", i), hold_at[i], exp_hold_at[i]);
        check("hold press pulses", seg_press, 1);
        run_ticks(1'b0, 24, 4);
        check("hold release pulses", seg_release, 1);
        check("hold release level", level, 0);
        $display("hold sequence: repeats=%0d", seg_hold);

        // Reset in the middle of PRESS_WAIT, button still held.
        clear_seg();
        run_ticks(1'b1, 10, 4);
        do_reset(1, 1'b1);
        run_ticks(1'b1, 23, 4);
        check("requalify no early press", seg_press, 0);
        check("requalify level low", level, 0);
        run_ticks(1'b1, 1, 4);
        check("requalify press pulses", seg_press, 1);
        check("requalify press_count", press_count, 1);
        run_ticks(1'b0, 24, 4);
        $display("reset mid-press: presses=%0d count=%0d", seg_press, press_count);

        // 256 full cycles with back-to-back ticks: counter wraps to 0.
        do_reset(2, 1'b0);
        clear_seg();
        for (int c = 0; c < 256; c++) begin
            run_ticks(1'b1, 24, 1);
            run_ticks(1'b0, 24, 1);
        end
        check("wrap press pulses", seg_press, 256);
        check("wrap release pulses", seg_release, 256);
        check("wrap press_count", press_count, 0);
        $display("wrap sequence: presses=%0d count=%0d", seg_press, press_count);

        // Random runs of pressed/released samples with random tick spacing.
        clear_seg();
        begin
            int done;
            done = 0;
            while (done < 3000) begin
                bit p;
                int len;
                p   = 1'($urandom_range(0, 1));
                len = $urandom_range(1, 40);
                if ($urandom_range(0, 49) == 0) do_reset(1, p);
                for (int i = 0; i < len; i++) apply_tick(p, $urandom_range(1, 4));
                done += len;
            end
            $display("random sequence: ticks=%0d presses=%0d releases=%0d", done, seg_press, seg_release);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
